// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter
// ---------------------------------------------------------------------------
// Purpose: shares the single cartridge SPI bus (in front of SPIMux) between
// N SPI masters. Ownership is granted one transaction at a time in
// round-robin order. Between two owners there is a deselect gap, during which
// every chip select is high. An optional watchdog revokes a grant that is
// held for too long.
//
// Ports:
//   SClk           in   system clock, all state changes on the rising edge
//   nReset         in   asynchronous assert, active-low reset
//   Req[N]         in   level request; master i wants, or still owns, the bus
//   ReqClkRunning  in   per-master SPI clock-run request
//   ReqClkStretch  in   per-master clock-stretch request
//   ReqDo[N]       in   per-master next MOSI bit
//   Grant[N]       out  registered one-hot (or zero) bus ownership
//   OutClkRunning  out  muxed clock-run request   (idle value 0)
//   OutClkStretch  out  muxed clock-stretch request (idle value 0)
//   OutDo          out  muxed MOSI bit            (idle value 1)
//   OutnSel[N]     out  active-low chip selects, equal to ~Grant
//   Busy           out  high while in GRANT or GAP
//   Timeout        out  one-cycle pulse, coincident with the watchdog revoking a grant
//   DbgState[2]    out  current FSM state (0 IDLE, 1 GRANT, 2 GAP)
//
// Handshake: Req[i] is a level. It rises to ask for the bus. The master owns
// the bus while Grant[i]=1. It drops Req[i] to release the bus, and it stops
// its SPI clock before doing so. The arbiter samples Req on every rising edge.
// No other acknowledgement exists.
// ---------------------------------------------------------------------------
module spi_bus_arbiter #(
  parameter int N          = 2,
  parameter int GAP_CYCLES = 4,
  parameter int MAX_HOLD   = 0
) (
  input  logic         SClk,
  input  logic         nReset,
  input  logic [N-1:0] Req,
  input  logic [N-1:0] ReqClkRunning,
  input  logic [N-1:0] ReqClkStretch,
  input  logic [N-1:0] ReqDo,
  output logic [N-1:0] Grant,
  output logic         OutClkRunning,
  output logic         OutClkStretch,
  output logic         OutDo,
  output logic [N-1:0] OutnSel,
  output logic         Busy,
  output logic         Timeout,
  output logic [1:0]   DbgState
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD);
  localparam logic [PW-1:0] IDX_LAST  = PW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] gidx_q, gidx_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  lock_q, lock_d;
  logic          timeout_q, timeout_d;

  // Round-robin pick among eligible requesters. A master is eligible when it
  // requests and is not locked out after a watchdog revocation. The search
  // starts at ptr_q and goes up to N-1. It then wraps around to the indices
  // below ptr_q.
  logic [N-1:0]  eligible;
  logic          arb_found;
  logic [PW-1:0] arb_idx;
  logic [N-1:0]  arb_onehot;
  logic [PW-1:0] arb_ptr_next;
  logic [HW-1:0] hold_inc;

  assign eligible = Req & ~lock_q;
  assign hold_inc = hold_q + HW'(1);

  always_comb begin
    arb_found    = 1'b0;
    arb_idx      = '0;
    arb_onehot   = '0;
    arb_ptr_next = '0;
    for (int i = 0; i < N; i++) begin
      if (!arb_found && (i >= int'(ptr_q)) && eligible[i]) begin
        arb_found = 1'b1;
        arb_idx   = PW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!arb_found && eligible[i]) begin
        arb_found = 1'b1;
        arb_idx   = PW'(i);
      end
    end
    arb_onehot[arb_idx] = 1'b1;
    arb_ptr_next = (arb_idx == IDX_LAST) ? '0 : arb_idx + PW'(1);
  end

  // Next-state logic. A lockout bit is cleared on any edge that samples the
  // master's Req low.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    gap_d     = gap_q;
    hold_d    = hold_q;
    lock_d    = lock_q & Req;
    timeout_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          state_d = S_GRANT;
          grant_d = arb_onehot;
          gidx_d  = arb_idx;
          ptr_d   = arb_ptr_next;
          hold_d  = '0;
        end
      end

      S_GRANT: begin
        if (!Req[gidx_q]) begin
          // A release wins over a watchdog expiry that falls in the same cycle.
          state_d = S_GAP;
          grant_d = '0;
          gap_d   = GW'(1);
        end else if ((MAX_HOLD > 0) && (hold_inc == HOLD_LAST)) begin
          state_d        = S_GAP;
          grant_d        = '0;
          gap_d          = GW'(1);
          hold_d         = hold_inc;
          timeout_d      = 1'b1;
          lock_d[gidx_q] = 1'b1;
        end else if (MAX_HOLD > 0) begin
          hold_d = hold_inc;
        end
      end

      S_GAP: begin
        // The counter holds the number of gap cycles so far, including the
        // current one. On the last gap cycle, arbitration happens in the same
        // transition.
        if (gap_q == GAP_LAST) begin
          gap_d = '0;
          if (arb_found) begin
            state_d = S_GRANT;
            grant_d = arb_onehot;
            gidx_d  = arb_idx;
            ptr_d   = arb_ptr_next;
            hold_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge SClk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      ptr_q     <= '0;
      gap_q     <= '0;
      hold_q    <= '0;
      lock_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      gap_q     <= gap_d;
      hold_q    <= hold_d;
      lock_q    <= lock_d;
      timeout_q <= timeout_d;
    end
  end

  // The muxed SPI controls follow the owner only in GRANT. In every other
  // state, including the cycle right after a release, they are forced idle.
  always_comb begin
    OutClkRunning = 1'b0;
    OutClkStretch = 1'b0;
    OutDo         = 1'b1;
    if (state_q == S_GRANT) begin
      OutClkRunning = ReqClkRunning[gidx_q];
      OutClkStretch = ReqClkStretch[gidx_q];
      OutDo         = ReqDo[gidx_q];
    end
  end

  assign Grant    = grant_q;
  assign OutnSel  = ~grant_q;
  assign Busy     = (state_q != S_IDLE);
  assign Timeout  = timeout_q;
  assign DbgState = state_q;

endmodule
